fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Clocked sequencer that drives the combinational control decoder. Holds the program
//  counter, decode mode (CurrState), previous instruction word and compare flags.
//  Runs the Start/Done handshake with the testbench and a cycle watchdog.
//  Sits between instruction ROM (address ProgCtr) and the decoder; registers the
//  decoder's NextState/BranchEn/Ack outputs each cycle.
// PARAMETERS
//  PC_W        10    program counter width; must be >= 9 (BranchTarget is 9 bits)
//  START_ADDR  0     PC value loaded on reset and on Start
//  MAX_CYCLES  4096  RUN cycles before forced halt (watchdog); must be >= 2
// PORTS
//  Clk              in   1     clock, all state updates on rising edge
//  Reset            in   1     synchronous, active-low reset
//  Start            in   1     level; high = hold/abort in IDLE; falling edge starts RUN
//  Instruction      in   9     current ROM word at ProgCtr (combinational ROM)
//  NextState        in   2     decoder next mode (00 reg, 01 target, 10 imm, 11 nop)
//  BranchEn         in   1     decoder: load PC from BranchTarget
//  BranchTarget     in   9     decoder branch address
//  CMPLoadEn        in   1     decoder: capture CMPBitsIn
//  CMPBitsIn        in   3     new compare flags {zero, equal, gt}
//  AckIn            in   1     decoder: program-done instruction executed
//  ProgCtr          out  PC_W  instruction ROM address
//  CurrState        out  2     registered decode mode to decoder
//  PrevInstruction  out  9     instruction word of previous RUN cycle
//  CMPBits          out  3     registered compare flags
//  Running          out  1     1 while in RUN
//  Done             out  1     1 while in HALT
//  Timeout          out  1     1 in HALT if watchdog caused halt
// BEHAVIOUR
//  - Reset low (sync): state IDLE, ProgCtr=START_ADDR, CurrState=00, PrevInstruction=0,
//    CMPBits=000, cycle count=0, StartSeen=0, Running=Done=Timeout=0. Overrides all.
//  - FSM states IDLE, RUN, HALT. Outputs are registered (no comb paths in->out).
//  - Start high in any state: next state IDLE, ProgCtr=START_ADDR, CurrState=00,
//    CMPBits=000, count=0, Done=Timeout=0, StartSeen=1 (abort mid-run is legal).
//  - IDLE->RUN when Start low and StartSeen=1 (first cycle after falling edge);
//    StartSeen cleared on entry. IDLE without a prior Start stays IDLE.
//  - RUN, each cycle: PrevInstruction<=Instruction; CurrState<=NextState;
//    ProgCtr<=BranchEn ? {zero-ext BranchTarget} : ProgCtr+1 (wraps 2^PC_W-1 -> 0);
//    CMPBits<=CMPBitsIn if CMPLoadEn else hold; count<=count+1.
//  - NextState=11 is registered as-is; decoder treats it as a bubble; no special case.
//  - RUN->HALT on AckIn=1: ProgCtr, CurrState, CMPBits, PrevInstruction hold; BranchEn
//    and CMPLoadEn that cycle are ignored (Ack wins). Done=1 from next cycle.
//  - RUN->HALT when count==MAX_CYCLES-1 and AckIn=0: Done=1, Timeout=1. If AckIn=1
//    same cycle, Timeout=0.
//  - HALT: all registers hold, Done=1 until Start high.
//  - Latency: decoder output at edge N is visible on ProgCtr/CurrState after edge N.
// TESTING
//  1 Reset low 2 cycles, Start 1 cycle then low -> RUN 1 cycle later, ProgCtr 0,1,2..
//  2 BranchEn=1, BranchTarget=9'h1A5 at PC 3 -> next ProgCtr=0x1A5, then 0x1A6.
//  3 NextState=01 with Instruction=9'h10C -> next CurrState=01, PrevInstruction=0x10C.
//  4 AckIn=1 with BranchEn=1 at PC 7 -> HALT, Done=1, ProgCtr stays 7, Timeout=0.
//  5 MAX_CYCLES=8, no Ack -> HALT after 8 RUN cycles, Done=1, Timeout=1.
//  6 Start high mid-RUN at PC 5 -> IDLE, ProgCtr=START_ADDR, CMPBits=000; restarts.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - sequencer <-> decoder/ROM/testbench signal bundle
interface fetch_sequencer_if #(
  parameter int PC_W = 10
);
  logic            Start;
  logic [8:0]      Instruction;
  logic [1:0]      NextState;
  logic            BranchEn;
  logic [8:0]      BranchTarget;
  logic            CMPLoadEn;
  logic [2:0]      CMPBitsIn;
  logic            AckIn;
  logic [PC_W-1:0] ProgCtr;
  logic [1:0]      CurrState;
  logic [8:0]      PrevInstruction;
  logic [2:0]      CMPBits;
  logic            Running;
  logic            Done;
  logic            Timeout;

  // Driver side: ROM, decoder and start/done handshake partner
  modport master (
    output Start, Instruction, NextState, BranchEn, BranchTarget,
           CMPLoadEn, CMPBitsIn, AckIn,
    input  ProgCtr, CurrState, PrevInstruction, CMPBits,
           Running, Done, Timeout
  );

  // Sequencer side
  modport slave (
    input  Start, Instruction, NextState, BranchEn, BranchTarget,
           CMPLoadEn, CMPBitsIn, AckIn,
    output ProgCtr, CurrState, PrevInstruction, CMPBits,
           Running, Done, Timeout
  );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter / decode-mode sequencer with start handshake and watchdog
module fetch_sequencer #(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0,
  parameter int MAX_CYCLES = 4096
) (
  input logic              Clk,
  input logic              Reset,
  fetch_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_CYCLES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  localparam logic [PC_W-1:0]  START_PC   = PC_W'(START_ADDR);
  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

  logic [1:0]       state;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  pc_next;
  logic [1:0]       mode;
  logic [8:0]       prev_instr;
  logic [2:0]       cmp_bits;
  logic [CNT_W-1:0] count;
  logic             start_seen;
  logic             timeout;
  logic             last_cycle;

  // Next fetch address: branch target (zero-extended) or sequential, wrapping at the top
  always_comb begin
    pc_next = pc + PC_W'(1);
    if (bus.BranchEn) begin
      pc_next = PC_W'(bus.BranchTarget);
    end
  end

  // Watchdog fires on the RUN cycle whose count is the last allowed one
  assign last_cycle = (count == LAST_CYCLE);

  // Sequencer state: reset, Start abort/arm, then IDLE/RUN/HALT behaviour
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= IDLE;
      pc         <= START_PC;
      mode       <= 2'b00;
      prev_instr <= 9'd0;
      cmp_bits   <= 3'b000;
      count      <= '0;
      start_seen <= 1'b0;
      timeout    <= 1'b0;
    end else if (bus.Start) begin
      // Start high holds the sequencer in IDLE and arms the falling-edge launch;
      // PrevInstruction deliberately survives an abort.
      state      <= IDLE;
      pc         <= START_PC;
      mode       <= 2'b00;
      cmp_bits   <= 3'b000;
      count      <= '0;
      start_seen <= 1'b1;
      timeout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_seen) begin
            state      <= RUN;
            start_seen <= 1'b0;
          end
        end
        RUN: begin
          if (bus.AckIn) begin
            // Program done: architectural state freezes, branch/compare load ignored
            state   <= HALT;
            timeout <= 1'b0;
          end else begin
            prev_instr <= bus.Instruction;
            mode       <= bus.NextState;
            pc         <= pc_next;
            if (bus.CMPLoadEn) begin
              cmp_bits <= bus.CMPBitsIn;
            end
            count <= count + CNT_W'(1);
            if (last_cycle) begin
              state   <= HALT;
              timeout <= 1'b1;
            end
          end
        end
        HALT: begin
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ProgCtr         = pc;
  assign bus.CurrState       = mode;
  assign bus.PrevInstruction = prev_instr;
  assign bus.CMPBits         = cmp_bits;
  assign bus.Running         = (state == RUN);
  assign bus.Done            = (state == HALT);
  assign bus.Timeout         = timeout;

endmodule
